// File: rtl/calc_arbiter_pkg.sv
// Shared definitions for the calculator arbiter: opcodes, FSM state encoding
// and the fill value used for error results.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Replicated WIDTH times to form the all-ones error result
    localparam logic ERR_FILL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_BUSY  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    function automatic logic is_div(input logic [1:0] op);
        return (op == OP_DIV);
    endfunction

endpackage

// File: rtl/calc_arbiter_if.sv
// Bundles the requester, ALU and response handshakes of the calculator arbiter.
// master = arbiter side, slave = requesters/ALU/consumer side.
interface calc_arbiter_if #(parameter int WIDTH = 8) ();

    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [3:0]         req_op;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic               alu_start;
    logic [1:0]         alu_op;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic               alu_done;
    logic [WIDTH-1:0]   alu_result;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_result;
    logic               rsp_err;

    modport master (
        input  req_valid, req_op, req_a, req_b, alu_done, alu_result, rsp_ready,
        output req_ready, alu_start, alu_op, alu_a, alu_b,
               rsp_valid, rsp_id, rsp_result, rsp_err
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, alu_done, alu_result, rsp_ready,
        input  req_ready, alu_start, alu_op, alu_a, alu_b,
               rsp_valid, rsp_id, rsp_result, rsp_err
    );

endinterface

// File: rtl/calc_rr_arbiter.sv
// Two-way round-robin grant; the last winner loses a tie on the next contest.
module calc_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic       o_grant_id,
    output logic [1:0] o_grant_oh
);

    logic r_last_grant;

    // Combinational winner selection from current requests and history
    always_comb begin
        o_grant_id = 1'b0;
        o_grant_oh = 2'b00;
        case (i_req)
            2'b01:   o_grant_id = 1'b0;
            2'b10:   o_grant_id = 1'b1;
            2'b11:   o_grant_id = ~r_last_grant;
            default: o_grant_id = 1'b0;
        endcase
        if (i_req != 2'b00) begin
            o_grant_oh = o_grant_id ? 2'b10 : 2'b01;
        end else begin
            o_grant_oh = 2'b00;
        end
    end

    // History register; reset to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (i_accept) begin
            r_last_grant <= o_grant_id;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one calculator ALU between two requesters: arbitrate, issue, wait
// for completion under a watchdog, then hold the response until consumed.
module calc_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    calc_arbiter_if.master bus
);
    import calc_pkg::*;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_t             r_state;
    logic [7:0]         r_wdog;
    logic               r_alu_start;
    logic [1:0]         r_alu_op;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_result;
    logic               r_rsp_err;

    logic               w_grant_id;
    logic [1:0]         w_grant_oh;
    logic               w_accept;
    logic [1:0]         w_op;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic               w_div0;

    calc_rr_arbiter u_rr (
        .clk        (clk),
        .rst        (reset),
        .i_req      (bus.req_valid),
        .i_accept   (w_accept),
        .o_grant_id (w_grant_id),
        .o_grant_oh (w_grant_oh)
    );

    // Handshake and winner's command selection; ready is gated by reset
    always_comb begin
        w_accept = (r_state == ST_IDLE) && (bus.req_valid != 2'b00) && !reset;
        if (w_accept) begin
            bus.req_ready = w_grant_oh;
        end else begin
            bus.req_ready = 2'b00;
        end
        if (w_grant_id) begin
            w_op = bus.req_op[3:2];
            w_a  = bus.req_a[2*WIDTH-1:WIDTH];
            w_b  = bus.req_b[2*WIDTH-1:WIDTH];
        end else begin
            w_op = bus.req_op[1:0];
            w_a  = bus.req_a[WIDTH-1:0];
            w_b  = bus.req_b[WIDTH-1:0];
        end
        w_div0 = is_div(w_op) && (w_b == {WIDTH{1'b0}});
    end

    assign bus.alu_start  = r_alu_start;
    assign bus.alu_op     = r_alu_op;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_err    = r_rsp_err;

    // Operation sequencer with operand latch and completion watchdog
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wdog       <= 8'd0;
            r_alu_start  <= 1'b0;
            r_alu_op     <= 2'b00;
            r_alu_a      <= {WIDTH{1'b0}};
            r_alu_b      <= {WIDTH{1'b0}};
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= {WIDTH{1'b0}};
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rsp_id <= w_grant_id;
                        if (w_div0) begin
                            r_rsp_result <= {WIDTH{1'b0}};
                            r_rsp_err    <= 1'b1;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= ST_RESP;
                        end else begin
                            r_alu_op    <= w_op;
                            r_alu_a     <= w_a;
                            r_alu_b     <= w_b;
                            r_alu_start <= 1'b1;
                            r_state     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_alu_start <= 1'b0;
                    r_wdog      <= 8'd0;
                    r_state     <= ST_BUSY;
                end
                ST_BUSY: begin
                    // Completion takes priority over an expiring watchdog
                    if (bus.alu_done) begin
                        r_rsp_result <= bus.alu_result;
                        r_rsp_err    <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= ST_RESP;
                    end else if (r_wdog == WDOG_LAST) begin
                        r_rsp_result <= {WIDTH{ERR_FILL}};
                        r_rsp_err    <= 1'b1;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed scoreboard bench for calc_arbiter with a behavioural single-cycle ALU.
module tb_calc_arbiter;

    typedef struct packed {
        logic       id;
        logic [7:0] res;
        logic       err;
    } rsp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   grant_cnt;
    int   start_cnt;
    bit   alu_en;
    bit   stray;
    logic       pend;
    logic [7:0] pend_res;

    rsp_t rq[$];
    logic gq[$];
    rsp_t got_r;
    logic got_g;

    calc_arbiter_if #(.WIDTH(8)) bus ();

    calc_arbiter #(.WIDTH(8), .TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a * b;
            default: return (b != 8'd0) ? a / b : 8'hFF;
        endcase
    endfunction

    // Behavioural ALU: done one cycle after start, plus an injectable stray pulse
    always @(negedge clk) begin
        bus.alu_done   = pend | stray;
        bus.alu_result = pend ? pend_res : (stray ? 8'h77 : 8'h00);
        pend           = bus.alu_start & alu_en;
        pend_res       = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
        if (bus.alu_start) start_cnt++;
    end

    // Response monitor
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            if (rq.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                got_r = rq.pop_front();
                check("rsp_id", {31'd0, bus.rsp_id}, {31'd0, got_r.id});
                check("rsp_result", {24'd0, bus.rsp_result}, {24'd0, got_r.res});
                check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, got_r.err});
            end
        end
    end

    // Grant monitor
    always @(negedge clk) begin
        if (!reset && (bus.req_ready & bus.req_valid) != 2'b00) begin
            grant_cnt++;
            if (gq.size() == 0) begin
                check("grant_unexpected", 32'd1, 32'd0);
            end else begin
                got_g = gq.pop_front();
                check("grant_id", {30'd0, bus.req_ready}, got_g ? 32'd2 : 32'd1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bit seen;
        seen = 1'b0;
        bus.req_op[2*id +: 2] = op;
        bus.req_a[8*id +: 8]  = a;
        bus.req_b[8*id +: 8]  = b;
        bus.req_valid[id]     = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.req_ready[id]) seen = 1'b1;
        end
        if (!seen) check("send_timeout", 32'd0, 32'd1);
        step();
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (!bus.rsp_valid && rq.size() == 0) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
        step();
    endtask

    task automatic wait_rsp_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) ok = 1'b1;
        end
        if (!ok) check("rsp_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int s0;
        int g0;
        logic [7:0] hold_res;
        total = 0; bad = 0; grant_cnt = 0; start_cnt = 0;
        alu_en = 1'b1; stray = 1'b0; pend = 1'b0; pend_res = 8'h00;
        reset = 1'b1;
        bus.req_valid = 2'b00; bus.req_op = 4'h0; bus.req_a = 16'h0; bus.req_b = 16'h0;
        bus.rsp_ready = 1'b1; bus.alu_done = 1'b0; bus.alu_result = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_alu_start", {31'd0, bus.alu_start}, 32'd0);
        check("rst_rsp_result", {24'd0, bus.rsp_result}, 32'd0);
        step();
        reset = 1'b0;
        step();

        // 1: single ADD, latency
        gq.push_back(1'b0);
        rq.push_back('{id: 1'b0, res: 8'd8, err: 1'b0});
        send(1'b0, 2'b00, 8'd3, 8'd5);
        @(negedge clk);
        check("t1_start", {31'd0, bus.alu_start}, 32'd1);
        check("t1_alu_a", {24'd0, bus.alu_a}, 32'd3);
        check("t1_alu_b", {24'd0, bus.alu_b}, 32'd5);
        check("t1_alu_op", {30'd0, bus.alu_op}, 32'd0);
        @(negedge clk);
        check("t1_start_pulse", {31'd0, bus.alu_start}, 32'd0);
        check("t1_op_held", {24'd0, bus.alu_a}, 32'd3);
        @(negedge clk);
        check("t1_rsp_latency", {31'd0, bus.rsp_valid}, 32'd1);
        wait_idle();

        // 3: divide by zero from requester 1, then a legal divide
        s0 = start_cnt;
        gq.push_back(1'b1);
        rq.push_back('{id: 1'b1, res: 8'd0, err: 1'b1});
        send(1'b1, 2'b11, 8'd10, 8'd0);
        @(negedge clk);
        check("t3_div0_latency", {31'd0, bus.rsp_valid}, 32'd1);
        wait_idle();
        check("t3_no_start", s0, start_cnt);
        gq.push_back(1'b1);
        rq.push_back('{id: 1'b1, res: 8'd5, err: 1'b0});
        send(1'b1, 2'b11, 8'd10, 8'd2);
        wait_idle();

        // 2: both requesters continuously valid
        bus.req_op = 4'b1001;
        bus.req_a  = {8'd3, 8'd5};
        bus.req_b  = {8'd5, 8'd3};
        for (int i = 0; i < 2; i++) begin
            gq.push_back(1'b0); gq.push_back(1'b1);
            rq.push_back('{id: 1'b0, res: 8'd2, err: 1'b0});
            rq.push_back('{id: 1'b1, res: 8'd15, err: 1'b0});
        end
        g0 = grant_cnt;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 100 && grant_cnt < g0 + 4; i++) @(negedge clk);
        check("t2_grants", grant_cnt - g0, 32'd4);
        step();
        bus.req_valid = 2'b00;
        wait_idle();

        // 4: watchdog timeout, stray done in IDLE, then normal op
        alu_en = 1'b0;
        gq.push_back(1'b0);
        rq.push_back('{id: 1'b0, res: 8'hFF, err: 1'b1});
        send(1'b0, 2'b00, 8'd1, 8'd1);
        @(negedge clk);
        check("t4_start", {31'd0, bus.alu_start}, 32'd1);
        n = 0;
        while (n < 200 && !bus.rsp_valid) begin
            @(negedge clk);
            n++;
        end
        check("t4_timeout_cycles", n, 32'd65);
        wait_idle();
        alu_en = 1'b1;
        stray = 1'b1;
        step();
        stray = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_stray_ignored", {31'd0, bus.rsp_valid}, 32'd0);
        end
        step();
        gq.push_back(1'b1);
        rq.push_back('{id: 1'b1, res: 8'd5, err: 1'b0});
        send(1'b1, 2'b01, 8'd9, 8'd4);
        wait_idle();

        // 5: response backpressure
        bus.rsp_ready = 1'b0;
        gq.push_back(1'b0);
        rq.push_back('{id: 1'b0, res: 8'd24, err: 1'b0});
        send(1'b0, 2'b10, 8'd4, 8'd6);
        bus.req_op[3:2] = 2'b00; bus.req_a[15:8] = 8'd2; bus.req_b[15:8] = 8'd2;
        bus.req_valid = 2'b10;
        wait_rsp_valid();
        hold_res = bus.rsp_result;
        check("t5_result", {24'd0, hold_res}, 32'd24);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("t5_hold_id", {31'd0, bus.rsp_id}, 32'd0);
            check("t5_hold_result", {24'd0, bus.rsp_result}, {24'd0, hold_res});
            check("t5_hold_err", {31'd0, bus.rsp_err}, 32'd0);
            check("t5_no_ready", {30'd0, bus.req_ready}, 32'd0);
        end
        step();
        bus.req_op[1:0] = 2'b00; bus.req_a[7:0] = 8'd7; bus.req_b[7:0] = 8'd7;
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b1;
        gq.push_back(1'b0);
        rq.push_back('{id: 1'b0, res: 8'd14, err: 1'b0});
        @(negedge clk);
        check("t5_no_bypass", {30'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        check("t5_idle_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("t5_idle_ready", {30'd0, bus.req_ready}, 32'd1);
        step();
        bus.req_valid = 2'b00;
        wait_idle();

        // 6: reset during BUSY
        alu_en = 1'b0;
        gq.push_back(1'b0);
        send(1'b0, 2'b01, 8'd5, 8'd6);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_alu_op", {30'd0, bus.alu_op}, 32'd0);
        check("t6_alu_a", {24'd0, bus.alu_a}, 32'd0);
        check("t6_alu_b", {24'd0, bus.alu_b}, 32'd0);
        check("t6_rsp_result", {24'd0, bus.rsp_result}, 32'd0);
        check("t6_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("t6_req_ready", {30'd0, bus.req_ready}, 32'd0);
        step();
        step();
        reset = 1'b0;
        alu_en = 1'b1;
        stray = 1'b1;
        step();
        stray = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_late_done", {31'd0, bus.rsp_valid}, 32'd0);
        end
        step();
        bus.req_op = 4'b0000;
        bus.req_a  = {8'd2, 8'd1};
        bus.req_b  = {8'd2, 8'd1};
        gq.push_back(1'b0);
        rq.push_back('{id: 1'b0, res: 8'd2, err: 1'b0});
        g0 = grant_cnt;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 20 && grant_cnt == g0; i++) @(negedge clk);
        step();
        bus.req_valid = 2'b00;
        wait_idle();

        check("rsp_queue_empty", rq.size(), 32'd0);
        check("grant_queue_empty", gq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_arbiter.md
Name:
calc_arbiter

Overview:
- Shares one Calculator ALU between two requesters and sequences each operation: arbitration, issue, completion wait, response.
- Sits between the command sources and the ALU datapath.
- Rejects divide-by-zero without using the ALU; enforces a completion watchdog.

Parameters:
- WIDTH, 8, operand/result width; matches the Calculator WIDTH.
- TIMEOUT, 64, max cycles from alu_start to alu_done before aborting; valid range 2..255.

Ports:
- clk input 1: clock, rising edge.
- reset input 1: asynchronous, active-high reset.
- req_valid input 2: bit i = requester i has a command.
- req_ready output 2: bit i = command i accepted this cycle when req_valid[i] is also high.
- req_op input 4: [2i+1:2i] = opcode of requester i.
- req_a input 2*WIDTH: [WIDTH*(i+1)-1:WIDTH*i] = operand A of requester i.
- req_b input 2*WIDTH: operand B of requester i, same packing as req_a.
- alu_start output 1: one-cycle pulse that launches the ALU.
- alu_op output 2: opcode to the ALU, held from start until done.
- alu_a output WIDTH: operand A to the ALU, held from start until done.
- alu_b output WIDTH: operand B to the ALU, held from start until done.
- alu_done input 1: ALU completion pulse.
- alu_result input WIDTH: ALU result, valid with alu_done.
- rsp_valid output 1: response available.
- rsp_ready input 1: consumer accepts the response.
- rsp_id output 1: requester index the response belongs to.
- rsp_result output WIDTH: result.
- rsp_err output 1: 1 = divide-by-zero or timeout.

Behaviour:
- Opcodes: 00 ADD, 01 SUB, 10 MUL, 11 DIV. Results are WIDTH bits; any truncation is done by the ALU and the block does not widen.
- FSM states: IDLE, ISSUE, BUSY, RESP. Reset state is IDLE.
- Reset values: req_ready=0, alu_start=0, alu_op/alu_a/alu_b=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, last_grant=1, so requester 0 wins first.
- IDLE, arbitration:
  - Grant is combinational. If only one req_valid bit is set, that requester wins.
  - If both are set, the requester other than last_grant wins.
  - req_ready is asserted only in IDLE and only for the winner. It is never asserted for both requesters.
- IDLE, accept:
  - On handshake, latch op, a, b and the id, and update last_grant.
  - If op==DIV and b==0, go to RESP with rsp_err=1 and rsp_result=0. The ALU is not started.
  - Otherwise go to ISSUE.
- ISSUE: alu_start=1 for exactly one cycle, with alu_op/a/b driven from the latched values. Then go to BUSY and clear the watchdog counter.
- BUSY, normal completion:
  - Counter increments every cycle.
  - When alu_done=1, capture alu_result into rsp_result with rsp_err=0, then go to RESP.
- BUSY, timeout:
  - If the counter reaches TIMEOUT-1 without alu_done, go to RESP with rsp_err=1 and rsp_result all-ones.
  - If alu_done and the timeout condition occur in the same cycle, done wins.
- alu_done outside BUSY is ignored: no state change, no capture.
- RESP:
  - rsp_valid=1. rsp_id, rsp_result and rsp_err stay stable until rsp_ready=1.
  - On rsp_valid & rsp_ready, go to IDLE. rsp_valid drops the next cycle.
  - No new command is accepted in the RESP cycle: no bypass.
- Latency with a single-cycle ALU and rsp_ready held high:
  - handshake at cycle N, alu_start at N+1, alu_done at N+2, rsp_valid at N+3.
  - The next req_ready is at N+4, giving one op per 4 cycles.
  - Divide-by-zero gives rsp_valid at N+1.
- Reset asserted mid-operation returns every output to its reset value immediately, without waiting for a clock edge. Any in-flight ALU result is discarded and later alu_done pulses are ignored.
- Requester inputs may change at any time while req_ready is low. Only values at the handshake are used.

Decomposition:
- Shared package calc_pkg holds:
  - the opcode constants ADD/SUB/MUL/DIV (2-bit);
  - the state encoding IDLE/ISSUE/BUSY/RESP;
  - the error result constant (all-ones).
- Natural sub-module: calc_rr_arbiter, a 2-way round-robin grant with a last_grant register that updates on handshake.
- The FSM, operand latch and watchdog stay in calc_arbiter.

Test Plan:
1. req0 ADD a=3 b=5 alone, ALU done 1 cycle after start, rsp_ready=1 -> alu_start 1 cycle after handshake with alu_a=3, alu_b=5; rsp_valid 3 cycles after handshake with id=0, result=8, err=0.
2. req0 and req1 both valid continuously (req0 SUB 5,3; req1 MUL 3,5) -> grants in order 0,1,0,1; responses id0=2, id1=15, alternating.
3. req1 DIV a=10 b=0 -> alu_start never pulses; rsp_valid the next cycle with id=1, result=0, err=1. Then DIV 10,2 -> result=5, err=0.
4. ALU never raises done, TIMEOUT=64 -> rsp_valid with err=1, result=8'hFF; a later stray alu_done in IDLE is ignored; the next command completes normally.
5. Response backpressure: rsp_ready low for 5 cycles -> rsp_valid, id, result and err stay stable; req_ready stays 0 throughout; IDLE is reached the cycle after rsp_ready rises.
6. Reset asserted during BUSY -> all outputs at reset values immediately. The late alu_done produces no response. After release, req0 wins first when both requesters are valid.
